rv_multicycle_ctrl: RTL and testbench
=====================================

// Module: rv_multicycle_ctrl
// PURPOSE
// Parametrised successor to the core's fixed-wait-state control sequencer. Drives fetch/decode/execute/
// memory/writeback for the multi-cycle RV32I datapath over a ready/valid memory handshake.
// Routes stores at or above MMIO_BASE to the MMIO port. Adds a memory timeout, fault codes,
// gated single-step and a retired-instruction counter. Sits between the board top level and the
// decoder/register-file/ALU/memory blocks.
// PARAMETERS
// XLEN       32           datapath and address width
// RESET_PC   32'h0        PC value loaded at reset
// MMIO_BASE  32'h00070000 stores with address >= this go to the MMIO port, not memory
// TIMEOUT    255          max cycles mem_req may wait for mem_ready (1..65535)
// HALT_OP    7'h7F        opcode that halts the core
// PORTS
// clk        in   1     system clock
// rst        in   1     synchronous reset, active low
// start      in   1     level; leaves IDLE
// step_mode  in   1     1 = pause before each fetch until step
// step       in   1     1-cycle pulse; releases one instruction in step_mode
// mem_req    out  1     memory request; held until mem_ready
// mem_addr   out  XLEN  request address
// mem_wsize  out  2     0=read, 1=byte, 2=half, 3=word store
// mem_wdata  out  XLEN  store data, MSB-lane aligned (byte<<24, half<<16)
// mem_rdata  in   XLEN  read data; valid when mem_ready=1
// mem_ready  in   1     completes the current request
// mem_err    in   1     qualifies mem_ready; access failed
// mmio_we    out  1     1-cycle MMIO store strobe
// mmio_addr  out  13    MMIO address = addr[12:0]
// mmio_wdata out  XLEN  raw rv2
// instr      out  XLEN  latched instruction (to decoder)
// dec_err, jump, jalr_n, branch, br_taken, mem_to_reg  in 1   decoder/branch-unit flags
// wsize_dec  in   2     decoded store size;  imm, rv1, rv2, alu_out  in XLEN  datapath values
// rd_data    out  XLEN  register write-back value;  reg_we  out 1  1-cycle write enable
// pc         out  XLEN  program counter;  state  out 4  FSM state;  instret  out 32  retired count
// fault      out  3     0 none, 1 decode, 2 bus error, 3 timeout, 4 misaligned PC
// BEHAVIOUR
// - Reset (rst=0 at posedge): state=IDLE, pc=RESET_PC, instr=0, instret=0, fault=0. All strobes,
//   mem_req, mem_addr, mem_wdata and rd_data = 0. Reset mid-request abandons it with no write.
// - States: IDLE(0) FETCH(1) DECODE(2) EXEC(3) MEM(4) WB(5) STEPWAIT(6) HALT(7) FAULT(8).
// - IDLE->FETCH when start=1. FETCH: if pc[1:0]!=0 -> FAULT(4). Else mem_req=1, addr=pc, wsize=0.
// - Handshake: addr/wsize/wdata stay stable while mem_req=1. On the first cycle mem_ready=1 the request
//   completes, and mem_req drops the next cycle. mem_err=1 with ready -> FAULT(2). A cycle counter
//   reaching TIMEOUT with no ready -> FAULT(3). The counter clears on every new request.
// - FETCH done: instr<=mem_rdata -> DECODE. DECODE -> EXEC, or HALT if instr[6:0]==HALT_OP, or FAULT(1) on dec_err.
// - EXEC -> MEM if mem_to_reg or wsize_dec!=0. Otherwise -> WB. alu_out is the effective address.
// - MEM store >= MMIO_BASE: no mem_req. mmio_we=1 for exactly one cycle, then -> WB. Other loads/stores
//   use the handshake; load data is captured on ready.
// - WB (1 cycle): reg_we=1. rd_data = pc+4 if jump, else captured load data if mem_to_reg,
//   else alu_out. Sign/zero extension stays in the datapath.
// - WB next-pc: jump&jalr_n -> pc+imm; jump&!jalr_n -> rv1+imm; branch&br_taken -> pc+imm;
//   else pc+4. All are modulo 2^XLEN. instret+1 (wraps 0xFFFFFFFF->0).
// - WB -> STEPWAIT if step_mode, else -> FETCH. STEPWAIT -> FETCH on step=1. A step pulse outside STEPWAIT is ignored.
// - HALT, FAULT: terminal until reset. HALT does not retire the halt instruction.
// TESTING
// - addi x1,x0,5 at 0, ready after 1 cycle -> reg_we pulse, rd_data=5, pc=4, instret=1.
// - mem_ready held low 255 cycles on fetch -> state=FAULT, fault=3, mem_req=0 afterwards.
// - sw to 0x00070010, rv2=0x41 -> mmio_we 1 cycle, mmio_addr=0x0010, mmio_wdata=0x41, no mem_req.
// - beq taken, imm=-8 at pc=0x20 -> pc=0x18. jalr rv1=0x101,imm=3 -> pc=0x104, rd_data=old pc+4.
// - step_mode=1: core parks in STEPWAIT after each WB. Each step pulse -> exactly one more instret.
// - rst=0 asserted while mem_req is waiting -> next cycle state=IDLE, pc=RESET_PC, no reg_we/mmio_we.

Source files
------------

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle RV32I control sequencer: fetch/decode/exec/mem/wb
// over a ready/valid memory port, with MMIO stores, faults and stepping.
module rv_multicycle_ctrl #(
   parameter int unsigned     XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = '0,
   parameter logic [XLEN-1:0] MMIO_BASE = 32'h0007_0000,
   parameter int unsigned     TIMEOUT   = 255,
   parameter logic [6:0]      HALT_OP   = 7'h7F
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            step_mode,
   input  logic            step,
   output logic            mem_req,
   output logic [XLEN-1:0] mem_addr,
   output logic [1:0]      mem_wsize,
   output logic [XLEN-1:0] mem_wdata,
   input  logic [XLEN-1:0] mem_rdata,
   input  logic            mem_ready,
   input  logic            mem_err,
   output logic            mmio_we,
   output logic [12:0]     mmio_addr,
   output logic [XLEN-1:0] mmio_wdata,
   output logic [XLEN-1:0] instr,
   input  logic            dec_err,
   input  logic            jump,
   input  logic            jalr_n,
   input  logic            branch,
   input  logic            br_taken,
   input  logic            mem_to_reg,
   input  logic [1:0]      wsize_dec,
   input  logic [XLEN-1:0] imm,
   input  logic [XLEN-1:0] rv1,
   input  logic [XLEN-1:0] rv2,
   input  logic [XLEN-1:0] alu_out,
   output logic [XLEN-1:0] rd_data,
   output logic            reg_we,
   output logic [XLEN-1:0] pc,
   output logic [3:0]      state,
   output logic [31:0]     instret,
   output logic [2:0]      fault
);

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_EXEC     = 4'd3,
      S_MEM      = 4'd4,
      S_WB       = 4'd5,
      S_STEPWAIT = 4'd6,
      S_HALT     = 4'd7,
      S_FAULT    = 4'd8
   } state_e;

   localparam logic [2:0] F_NONE = 3'd0;
   localparam logic [2:0] F_DEC  = 3'd1;
   localparam logic [2:0] F_BUS  = 3'd2;
   localparam logic [2:0] F_TMO  = 3'd3;
   localparam logic [2:0] F_ALGN = 3'd4;

   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
   localparam logic [XLEN-1:0] FOUR = XLEN'(4);

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] instr_q, instr_d;
   logic [31:0]     instret_q, instret_d;
   logic [2:0]      fault_q, fault_d;
   logic            req_q, req_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [1:0]      wsize_q, wsize_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic [XLEN-1:0] load_q, load_d;
   logic [15:0]     tmo_q, tmo_d;
   logic            mmio_q, mmio_d;
   logic            mmio_we_q, mmio_we_d;
   logic [12:0]     mmio_addr_q, mmio_addr_d;
   logic [XLEN-1:0] mmio_wdata_q, mmio_wdata_d;

   logic            fetch_go;
   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] npc;
   logic [XLEN-1:0] st_data;
   logic [XLEN-1:0] wb_val;
   logic            is_store;

   // Write-back value and next PC, both only meaningful in WB
   always_comb begin
      wb_val = alu_out;
      if (jump) begin
         wb_val = pc_q + FOUR;
      end else if (mem_to_reg) begin
         wb_val = load_q;
      end
      npc = pc_q + FOUR;
      if (jump && jalr_n) begin
         npc = pc_q + imm;
      end else if (jump) begin
         npc = rv1 + imm;
      end else if (branch && br_taken) begin
         npc = pc_q + imm;
      end
   end

   // Store data placed in the MSB lanes according to size
   always_comb begin
      is_store = (wsize_dec != 2'd0);
      unique case (wsize_dec)
         2'd1:    st_data = rv2 << (XLEN - 8);
         2'd2:    st_data = rv2 << (XLEN - 16);
         default: st_data = rv2;
      endcase
   end

   // Sequencer next-state and request set-up
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      instr_d      = instr_q;
      instret_d    = instret_q;
      fault_d      = fault_q;
      req_d        = req_q;
      addr_d       = addr_q;
      wsize_d      = wsize_q;
      wdata_d      = wdata_q;
      load_d       = load_q;
      tmo_d        = tmo_q;
      mmio_d       = mmio_q;
      mmio_we_d    = 1'b0;
      mmio_addr_d  = mmio_addr_q;
      mmio_wdata_d = mmio_wdata_q;
      fetch_go     = 1'b0;
      fetch_pc     = pc_q;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               fetch_go = 1'b1;
            end
         end
         S_FETCH: begin
            if (pc_q[1:0] != 2'b00) begin
               req_d   = 1'b0;
               fault_d = F_ALGN;
               state_d = S_FAULT;
            end else if (mem_ready) begin
               req_d = 1'b0;
               if (mem_err) begin
                  fault_d = F_BUS;
                  state_d = S_FAULT;
               end else begin
                  instr_d = mem_rdata;
                  state_d = S_DECODE;
               end
            end else if (tmo_q == TMO_LAST) begin
               req_d   = 1'b0;
               fault_d = F_TMO;
               state_d = S_FAULT;
            end else begin
               tmo_d = tmo_q + 16'd1;
            end
         end
         S_DECODE: begin
            if (instr_q[6:0] == HALT_OP) begin
               state_d = S_HALT;
            end else if (dec_err) begin
               fault_d = F_DEC;
               state_d = S_FAULT;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (mem_to_reg || is_store) begin
               state_d = S_MEM;
               tmo_d   = '0;
               if (is_store && (alu_out >= MMIO_BASE)) begin
                  mmio_d       = 1'b1;
                  mmio_we_d    = 1'b1;
                  mmio_addr_d  = alu_out[12:0];
                  mmio_wdata_d = rv2;
               end else begin
                  mmio_d  = 1'b0;
                  req_d   = 1'b1;
                  addr_d  = alu_out;
                  wsize_d = wsize_dec;
                  wdata_d = is_store ? st_data : '0;
               end
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            if (mmio_q) begin
               state_d = S_WB;
            end else if (mem_ready) begin
               req_d = 1'b0;
               if (mem_err) begin
                  fault_d = F_BUS;
                  state_d = S_FAULT;
               end else begin
                  load_d  = mem_rdata;
                  state_d = S_WB;
               end
            end else if (tmo_q == TMO_LAST) begin
               req_d   = 1'b0;
               fault_d = F_TMO;
               state_d = S_FAULT;
            end else begin
               tmo_d = tmo_q + 16'd1;
            end
         end
         S_WB: begin
            pc_d      = npc;
            instret_d = instret_q + 32'd1;
            if (step_mode) begin
               state_d = S_STEPWAIT;
            end else begin
               fetch_go = 1'b1;
               fetch_pc = npc;
            end
         end
         S_STEPWAIT: begin
            if (step) begin
               fetch_go = 1'b1;
            end
         end
         default: begin
            req_d = 1'b0;
         end
      endcase

      // A misaligned PC enters FETCH without raising a request
      if (fetch_go) begin
         state_d = S_FETCH;
         req_d   = (fetch_pc[1:0] == 2'b00);
         addr_d  = fetch_pc;
         wsize_d = 2'd0;
         wdata_d = '0;
         tmo_d   = '0;
      end
   end

   // State and datapath-control registers with synchronous reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         pc_q         <= RESET_PC;
         instr_q      <= '0;
         instret_q    <= '0;
         fault_q      <= F_NONE;
         req_q        <= 1'b0;
         addr_q       <= '0;
         wsize_q      <= 2'd0;
         wdata_q      <= '0;
         load_q       <= '0;
         tmo_q        <= '0;
         mmio_q       <= 1'b0;
         mmio_we_q    <= 1'b0;
         mmio_addr_q  <= '0;
         mmio_wdata_q <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         instr_q      <= instr_d;
         instret_q    <= instret_d;
         fault_q      <= fault_d;
         req_q        <= req_d;
         addr_q       <= addr_d;
         wsize_q      <= wsize_d;
         wdata_q      <= wdata_d;
         load_q       <= load_d;
         tmo_q        <= tmo_d;
         mmio_q       <= mmio_d;
         mmio_we_q    <= mmio_we_d;
         mmio_addr_q  <= mmio_addr_d;
         mmio_wdata_q <= mmio_wdata_d;
      end
   end

   assign mem_req    = req_q;
   assign mem_addr   = addr_q;
   assign mem_wsize  = wsize_q;
   assign mem_wdata  = wdata_q;
   assign mmio_we    = mmio_we_q;
   assign mmio_addr  = mmio_addr_q;
   assign mmio_wdata = mmio_wdata_q;
   assign instr      = instr_q;
   assign reg_we     = (state_q == S_WB);
   assign rd_data    = (state_q == S_WB) ? wb_val : '0;
   assign pc         = pc_q;
   assign state      = state_q;
   assign instret    = instret_q;
   assign fault      = fault_q;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Directed bench for rv_multicycle_ctrl: instruction flows,
// MMIO routing, step mode, faults, timeout and reset abort.
module tb_rv_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        rst, start, step_mode, step;
   logic        mem_req, mem_ready, mem_err;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [1:0]  mem_wsize, wsize_dec;
   logic        mmio_we;
   logic [12:0] mmio_addr;
   logic [31:0] mmio_wdata, instr;
   logic        dec_err, jump, jalr_n, branch, br_taken, mem_to_reg;
   logic [31:0] imm, rv1, rv2, alu_out, rd_data, pc, instret;
   logic        reg_we;
   logic [3:0]  state;
   logic [2:0]  fault;

   int ncmp = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   rv_multicycle_ctrl dut (
      .clk(clk), .rst(rst), .start(start),
      .step_mode(step_mode), .step(step),
      .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_wsize(mem_wsize), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .mem_err(mem_err), .mmio_we(mmio_we),
      .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata),
      .instr(instr), .dec_err(dec_err), .jump(jump),
      .jalr_n(jalr_n), .branch(branch),
      .br_taken(br_taken), .mem_to_reg(mem_to_reg),
      .wsize_dec(wsize_dec), .imm(imm), .rv1(rv1),
      .rv2(rv2), .alu_out(alu_out), .rd_data(rd_data),
      .reg_we(reg_we), .pc(pc), .state(state),
      .instret(instret), .fault(fault)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      ncmp++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic set_dec(input logic j, input logic jn,
                          input logic b, input logic bt,
                          input logic m2r, input logic [1:0] ws,
                          input logic [31:0] im, input logic [31:0] r1,
                          input logic [31:0] r2, input logic [31:0] alu);
      dec_err = 0; jump = j; jalr_n = jn; branch = b;
      br_taken = bt; mem_to_reg = m2r; wsize_dec = ws;
      imm = im; rv1 = r1; rv2 = r2; alu_out = alu;
   endtask

   task automatic fetch(input logic [31:0] apc, input logic [31:0] w,
                        input int lat);
      for (int i = 0; i < 10 && !mem_req; i++) tick();
      chk("fetch_req", {31'b0, mem_req}, 32'd1);
      chk("fetch_addr", mem_addr, apc);
      chk("fetch_wsize", {30'b0, mem_wsize}, 32'd0);
      for (int i = 0; i < lat; i++) begin
         tick();
         chk("fetch_hold", mem_addr, apc);
      end
      mem_ready = 1; mem_rdata = w;
      tick();
      mem_ready = 0;
      chk("fetch_dec", {28'b0, state}, 32'd2);
      chk("fetch_instr", instr, w);
      chk("fetch_drop", {31'b0, mem_req}, 32'd0);
   endtask

   task automatic mem_xfer(input logic [31:0] a, input logic [1:0] ws,
                           input logic [31:0] wd, input logic [31:0] rd,
                           input logic err, input int lat);
      chk("mem_state", {28'b0, state}, 32'd4);
      chk("mem_req", {31'b0, mem_req}, 32'd1);
      chk("mem_addr", mem_addr, a);
      chk("mem_wsize", {30'b0, mem_wsize}, {30'b0, ws});
      chk("mem_wdata", mem_wdata, wd);
      for (int i = 0; i < lat; i++) begin
         tick();
         chk("mem_hold", mem_wdata, wd);
      end
      mem_ready = 1; mem_err = err; mem_rdata = rd;
      tick();
      mem_ready = 0; mem_err = 0;
   endtask

   task automatic exec_wb();
      tick();
      chk("exec_state", {28'b0, state}, 32'd3);
      tick();
   endtask

   task automatic wb_check(input string tag, input logic [31:0] rd,
                           input logic [31:0] npc, input logic [31:0] ir);
      chk({tag, "_wb"}, {28'b0, state}, 32'd5);
      chk({tag, "_we"}, {31'b0, reg_we}, 32'd1);
      chk({tag, "_rd"}, rd_data, rd);
      tick();
      chk({tag, "_pc"}, pc, npc);
      chk({tag, "_iret"}, instret, ir);
      chk({tag, "_we0"}, {31'b0, reg_we}, 32'd0);
   endtask

   task automatic do_reset();
      rst = 0;
      tick();
      tick();
      rst = 1;
   endtask

   initial begin
      int n;
      rst = 0; start = 0; step_mode = 0; step = 0;
      mem_ready = 0; mem_err = 0; mem_rdata = 0;
      set_dec(0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0);
      do_reset();
      chk("rst_state", {28'b0, state}, 32'd0);
      chk("rst_pc", pc, 32'h0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_iret", instret, 32'h0);
      chk("rst_fault", {29'b0, fault}, 32'd0);
      chk("rst_req", {31'b0, mem_req}, 32'd0);
      chk("rst_addr", mem_addr, 32'h0);
      chk("rst_rd", rd_data, 32'h0);
      chk("rst_we", {30'b0, reg_we, mmio_we}, 32'd0);
      start = 1;

      set_dec(0, 0, 0, 0, 0, 2'd0, 5, 0, 0, 32'd5);
      fetch(32'h0, 32'h0050_0093, 1);
      exec_wb();
      wb_check("addi", 32'd5, 32'h4, 32'd1);

      set_dec(0, 0, 0, 0, 0, 2'd3, 32'h10, 0, 32'h41, 32'h0007_0010);
      fetch(32'h4, 32'h0410_2823, 0);
      tick();
      tick();
      chk("mmio_state", {28'b0, state}, 32'd4);
      chk("mmio_we", {31'b0, mmio_we}, 32'd1);
      chk("mmio_addr", {19'b0, mmio_addr}, 32'h10);
      chk("mmio_wdata", mmio_wdata, 32'h41);
      chk("mmio_noreq", {31'b0, mem_req}, 32'd0);
      tick();
      chk("mmio_we0", {31'b0, mmio_we}, 32'd0);
      chk("mmio_noreq2", {31'b0, mem_req}, 32'd0);
      wb_check("sw_mmio", 32'h0007_0010, 32'h8, 32'd2);

      set_dec(0, 0, 0, 0, 0, 2'd1, 0, 0, 32'h1234_5678, 32'h100);
      fetch(32'h8, 32'h0020_8023, 0);
      tick();
      tick();
      mem_xfer(32'h100, 2'd1, 32'h7800_0000, 0, 0, 2);
      wb_check("sb", 32'h100, 32'hC, 32'd3);

      set_dec(0, 0, 0, 0, 1, 2'd0, 0, 0, 0, 32'h200);
      fetch(32'hC, 32'h2000_2083, 0);
      tick();
      tick();
      mem_xfer(32'h200, 2'd0, 32'h0, 32'hCAFE_F00D, 0, 1);
      wb_check("lw", 32'hCAFE_F00D, 32'h10, 32'd4);

      set_dec(1, 1, 0, 0, 0, 2'd0, 32'h10, 0, 0, 32'hDEAD);
      fetch(32'h10, 32'h0100_00EF, 0);
      exec_wb();
      wb_check("jal", 32'h14, 32'h20, 32'd5);

      set_dec(0, 0, 1, 1, 0, 2'd0, 32'hFFFF_FFF8, 0, 0, 32'h0);
      fetch(32'h20, 32'hFE00_0CE3, 0);
      exec_wb();
      wb_check("beq", 32'h0, 32'h18, 32'd6);

      set_dec(1, 0, 0, 0, 0, 2'd0, 32'h3, 32'h101, 0, 32'h999);
      fetch(32'h18, 32'h0030_80E7, 0);
      exec_wb();
      wb_check("jalr", 32'h1C, 32'h104, 32'd7);

      set_dec(0, 0, 1, 0, 0, 2'd0, 32'hFFFF_FFF8, 0, 0, 32'h1);
      fetch(32'h104, 32'hFE00_1CE3, 0);
      exec_wb();
      wb_check("bnt", 32'h1, 32'h108, 32'd8);

      step_mode = 1;
      set_dec(0, 0, 0, 0, 0, 2'd0, 7, 0, 0, 32'd7);
      fetch(32'h108, 32'h0070_0093, 0);
      exec_wb();
      wb_check("step1", 32'd7, 32'h10C, 32'd9);
      chk("park", {28'b0, state}, 32'd6);
      repeat (3) tick();
      chk("park_hold", {28'b0, state}, 32'd6);
      chk("park_noreq", {31'b0, mem_req}, 32'd0);
      chk("park_iret", instret, 32'd9);
      step = 1;
      tick();
      step = 0;
      chk("step_go", {28'b0, state}, 32'd1);
      fetch(32'h10C, 32'h0070_0093, 0);
      exec_wb();
      wb_check("step2", 32'd7, 32'h110, 32'd10);
      chk("park2", {28'b0, state}, 32'd6);
      step_mode = 0;
      step = 1;
      tick();
      step = 0;

      set_dec(0, 0, 0, 0, 1, 2'd0, 0, 0, 0, 32'h300);
      fetch(32'h110, 32'h3000_2083, 0);
      tick();
      tick();
      mem_xfer(32'h300, 2'd0, 32'h0, 32'h0, 1, 0);
      chk("berr_state", {28'b0, state}, 32'd8);
      chk("berr_fault", {29'b0, fault}, 32'd2);
      chk("berr_req", {31'b0, mem_req}, 32'd0);
      chk("berr_we", {31'b0, reg_we}, 32'd0);
      repeat (3) tick();
      chk("berr_stay", {28'b0, state}, 32'd8);
      chk("berr_iret", instret, 32'd10);

      do_reset();
      chk("r2_fault", {29'b0, fault}, 32'd0);
      tick();
      chk("abort_req", {31'b0, mem_req}, 32'd1);
      tick();
      rst = 0;
      tick();
      chk("abort_state", {28'b0, state}, 32'd0);
      chk("abort_pc", pc, 32'h0);
      chk("abort_req0", {31'b0, mem_req}, 32'd0);
      chk("abort_we", {30'b0, reg_we, mmio_we}, 32'd0);
      chk("abort_iret", instret, 32'd0);
      rst = 1;

      n = 0;
      for (int i = 0; i < 400; i++) begin
         tick();
         if (mem_req) n++;
         if (state == 4'd8) break;
      end
      chk("tmo_cycles", n, 32'd255);
      chk("tmo_state", {28'b0, state}, 32'd8);
      chk("tmo_fault", {29'b0, fault}, 32'd3);
      tick();
      chk("tmo_req", {31'b0, mem_req}, 32'd0);

      do_reset();
      set_dec(0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0);
      fetch(32'h0, 32'h0000_007F, 0);
      tick();
      chk("halt_state", {28'b0, state}, 32'd7);
      repeat (2) tick();
      chk("halt_stay", {28'b0, state}, 32'd7);
      chk("halt_iret", instret, 32'd0);
      chk("halt_we", {31'b0, reg_we}, 32'd0);

      do_reset();
      set_dec(1, 1, 0, 0, 0, 2'd0, 32'h2, 0, 0, 0);
      fetch(32'h0, 32'h0020_00EF, 0);
      exec_wb();
      wb_check("jal2", 32'h4, 32'h2, 32'd1);
      chk("algn_noreq", {31'b0, mem_req}, 32'd0);
      tick();
      chk("algn_state", {28'b0, state}, 32'd8);
      chk("algn_fault", {29'b0, fault}, 32'd4);

      do_reset();
      set_dec(0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0);
      dec_err = 1;
      fetch(32'h0, 32'hFFFF_FFF3, 0);
      tick();
      chk("decerr_state", {28'b0, state}, 32'd8);
      chk("decerr_fault", {29'b0, fault}, 32'd1);
      dec_err = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
